wide_alu_axi_slave: RTL and testbench

// AXI4 slave terminating the SoC interconnect's wide-ALU AXI port (32b addr/data).

---
 rtl/wide_alu_axi_slave.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_wide_alu_axi_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_alu_axi_slave.sv
// AXI4 slave holding two wide operands and a result register, with a chunked
// ADD/SUB/XOR/AND engine that processes one 32-bit word per cycle, LSW first.

package pkg_soc_interconnect;
  localparam int AXI_ID_OUT_WIDTH = 4;
endpackage

module wide_alu_axi_slave #(
  parameter int AXI_ID_WIDTH   = pkg_soc_interconnect::AXI_ID_OUT_WIDTH,
  parameter int AXI_USER_WIDTH = 6,
  parameter int WIDE_WIDTH     = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [AXI_ID_WIDTH-1:0]   slv_aw_id,
  input  logic [31:0]               slv_aw_addr,
  input  logic [7:0]                slv_aw_len,
  input  logic [2:0]                slv_aw_size,
  input  logic [1:0]                slv_aw_burst,
  input  logic                      slv_aw_lock,
  input  logic [3:0]                slv_aw_cache,
  input  logic [2:0]                slv_aw_prot,
  input  logic [3:0]                slv_aw_qos,
  input  logic [3:0]                slv_aw_region,
  input  logic [AXI_USER_WIDTH-1:0] slv_aw_user,
  input  logic                      slv_aw_valid,
  output logic                      slv_aw_ready,
  input  logic [31:0]               slv_w_data,
  input  logic [3:0]                slv_w_strb,
  input  logic                      slv_w_last,
  input  logic [AXI_USER_WIDTH-1:0] slv_w_user,
  input  logic                      slv_w_valid,
  output logic                      slv_w_ready,
  output logic [AXI_ID_WIDTH-1:0]   slv_b_id,
  output logic [1:0]                slv_b_resp,
  output logic [AXI_USER_WIDTH-1:0] slv_b_user,
  output logic                      slv_b_valid,
  input  logic                      slv_b_ready,
  input  logic [AXI_ID_WIDTH-1:0]   slv_ar_id,
  input  logic [31:0]               slv_ar_addr,
  input  logic [7:0]                slv_ar_len,
  input  logic [2:0]                slv_ar_size,
  input  logic [1:0]                slv_ar_burst,
  input  logic                      slv_ar_lock,
  input  logic [3:0]                slv_ar_cache,
  input  logic [2:0]                slv_ar_prot,
  input  logic [3:0]                slv_ar_qos,
  input  logic [3:0]                slv_ar_region,
  input  logic [AXI_USER_WIDTH-1:0] slv_ar_user,
  input  logic                      slv_ar_valid,
  output logic                      slv_ar_ready,
  output logic [AXI_ID_WIDTH-1:0]   slv_r_id,
  output logic [31:0]               slv_r_data,
  output logic [1:0]                slv_r_resp,
  output logic                      slv_r_last,
  output logic [AXI_USER_WIDTH-1:0] slv_r_user,
  output logic                      slv_r_valid,
  input  logic                      slv_r_ready,
  output logic                      busy_o,
  output logic                      done_irq_o
);

  localparam int WORDS = WIDE_WIDTH / 32;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} axi_state_e;

  // Valid/ready protocol: a transfer happens on a rising clk_i edge where both
  // valid and ready are high; valid, once raised, holds until that edge.
  axi_state_e              state;
  logic                    rdy_en;
  logic [AXI_ID_WIDTH-1:0] txn_id;
  logic [31:0]             txn_addr;
  logic [7:0]              txn_len;
  logic [7:0]              beat;
  logic [2:0]              txn_size;
  logic [1:0]              txn_burst;
  logic                    wr_err;

  logic [31:0] opa [WORDS];
  logic [31:0] opb [WORDS];
  logic [31:0] res [WORDS];
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic        carry;
  logic        done_irq;
  logic        chain_c;
  logic [KW-1:0] k;

  logic [1:0]    region;
  logic [5:0]    widx;
  logic          idx_ok;
  logic [KW-1:0] kidx;
  logic [31:0]   next_addr;
  logic [31:0]   rd_data;
  logic          rd_err;
  logic          wr_beat_err;
  logic          w_fire;
  logic          w_ok;
  logic          start;
  logic          clear_done;

  assign region    = txn_addr[9:8];
  assign widx      = txn_addr[7:2];
  assign idx_ok    = (32'(widx) < WORDS);
  assign kidx      = widx[KW-1:0];
  assign next_addr = (txn_burst == 2'b00) ? txn_addr : txn_addr + 32'd4;

  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    if (txn_size != 3'd2) begin
      rd_err = 1'b1;
    end else begin
      case (region)
        2'd0:    if (idx_ok) rd_data = opa[kidx]; else rd_err = 1'b1;
        2'd1:    if (idx_ok) rd_data = opb[kidx]; else rd_err = 1'b1;
        2'd2:    if (idx_ok) rd_data = res[kidx]; else rd_err = 1'b1;
        default: begin
          if (widx == 6'd0)      rd_data = {30'd0, op};
          else if (widx == 6'd1) rd_data = {29'd0, carry, done, busy};
          else                   rd_err  = 1'b1;
        end
      endcase
    end
  end

  // Operand and CTRL writes are refused while the engine is running.
  always_comb begin
    wr_beat_err = 1'b0;
    if (txn_size != 3'd2) begin
      wr_beat_err = 1'b1;
    end else begin
      case (region)
        2'd0, 2'd1: wr_beat_err = !idx_ok || busy;
        2'd2:       wr_beat_err = 1'b1;
        default:    wr_beat_err = (widx == 6'd0) ? busy : (widx != 6'd1);
      endcase
    end
  end

  assign w_fire     = (state == WDATA) && slv_w_valid;
  assign w_ok       = w_fire && !wr_beat_err;
  assign start      = w_ok && (region == 2'd3) && (widx == 6'd0) && slv_w_strb[0] && slv_w_data[4];
  assign clear_done = w_ok && (region == 2'd3) && (widx == 6'd1) && slv_w_strb[0] && slv_w_data[1];

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = strb[i] ? nw[i*8 +: 8] : cur[i*8 +: 8];
    return m;
  endfunction

  logic [31:0] a_k, b_k, b_eff, chunk_res;
  logic [32:0] sum;
  assign a_k   = opa[k];
  assign b_k   = opb[k];
  assign b_eff = (op == OP_SUB) ? ~b_k : b_k;
  assign sum   = {1'b0, a_k} + {1'b0, b_eff} + {32'd0, chain_c};

  always_comb begin
    case (op)
      OP_XOR:  chunk_res = a_k ^ b_k;
      OP_AND:  chunk_res = a_k & b_k;
      default: chunk_res = sum[31:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WORDS; i++) begin
        opa[i] <= '0;
        opb[i] <= '0;
        res[i] <= '0;
      end
      op       <= OP_ADD;
      busy     <= 1'b0;
      done     <= 1'b0;
      carry    <= 1'b0;
      done_irq <= 1'b0;
      chain_c  <= 1'b0;
      k        <= '0;
    end else begin
      done_irq <= 1'b0;
      if (w_ok) begin
        case (region)
          2'd0: opa[kidx] <= merge(opa[kidx], slv_w_data, slv_w_strb);
          2'd1: opb[kidx] <= merge(opb[kidx], slv_w_data, slv_w_strb);
          2'd3: if (widx == 6'd0 && slv_w_strb[0]) op <= slv_w_data[1:0];
          default: ;
        endcase
      end
      if (clear_done) done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        k       <= '0;
        chain_c <= (slv_w_data[1:0] == OP_SUB);
      end else if (busy) begin
        res[k]  <= chunk_res;
        chain_c <= sum[32];
        if (k == KW'(WORDS - 1)) begin
          // A set on the completion edge overrides a simultaneous W1C above.
          busy     <= 1'b0;
          done_irq <= 1'b1;
          done     <= 1'b1;
          carry    <= op[1] ? 1'b0 : sum[32];
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      txn_id    <= '0;
      txn_addr  <= '0;
      txn_len   <= '0;
      txn_size  <= '0;
      txn_burst <= '0;
      beat      <= '0;
      wr_err    <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      case (state)
        IDLE: begin
          if (slv_aw_valid && slv_aw_ready) begin
            txn_id    <= slv_aw_id;
            txn_addr  <= slv_aw_addr;
            txn_len   <= slv_aw_len;
            txn_size  <= slv_aw_size;
            txn_burst <= slv_aw_burst;
            beat      <= '0;
            wr_err    <= 1'b0;
            state     <= WDATA;
          end else if (slv_ar_valid && slv_ar_ready) begin
            txn_id    <= slv_ar_id;
            txn_addr  <= slv_ar_addr;
            txn_len   <= slv_ar_len;
            txn_size  <= slv_ar_size;
            txn_burst <= slv_ar_burst;
            beat      <= '0;
            state     <= RDATA;
          end
        end
        WDATA: begin
          if (slv_w_valid) begin
            wr_err <= wr_err | wr_beat_err;
            if (slv_w_last || beat == txn_len) begin
              state <= WRESP;
            end else begin
              beat     <= beat + 8'd1;
              txn_addr <= next_addr;
            end
          end
        end
        WRESP: if (slv_b_ready) state <= IDLE;
        RDATA: begin
          if (slv_r_ready) begin
            if (beat == txn_len) begin
              state <= IDLE;
            end else begin
              beat     <= beat + 8'd1;
              txn_addr <= next_addr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // AR is held off whenever AW is presented so a simultaneous write wins.
  assign slv_aw_ready = (state == IDLE) && rdy_en;
  assign slv_ar_ready = (state == IDLE) && rdy_en && !slv_aw_valid;
  assign slv_w_ready  = (state == WDATA);
  assign slv_b_valid  = (state == WRESP);
  assign slv_b_id     = txn_id;
  assign slv_b_resp   = wr_err ? RESP_SLVERR : RESP_OKAY;
  assign slv_b_user   = '0;
  assign slv_r_valid  = (state == RDATA);
  assign slv_r_id     = txn_id;
  assign slv_r_data   = (state == RDATA) ? rd_data : 32'd0;
  assign slv_r_resp   = rd_err ? RESP_SLVERR : RESP_OKAY;
  assign slv_r_last   = (state == RDATA) && (beat == txn_len);
  assign slv_r_user   = '0;
  assign busy_o       = busy;
  assign done_irq_o   = done_irq;

  logic unused_ok;
  assign unused_ok = ^{slv_aw_lock, slv_aw_cache, slv_aw_prot, slv_aw_qos, slv_aw_region,
                       slv_aw_user, slv_w_user, slv_ar_lock, slv_ar_cache, slv_ar_prot,
                       slv_ar_qos, slv_ar_region, slv_ar_user, txn_addr[31:10], txn_addr[1:0]};

endmodule

// File: tb/tb_wide_alu_axi_slave.sv
// Directed bench for wide_alu_axi_slave: register map, bursts, engine ops,
// error responses, arbitration and reset behaviour.

module tb_wide_alu_axi_slave;
  localparam int IDW = 4;
  localparam int UW  = 6;
  localparam int W   = 39;  // {id[3:0], resp[1:0], last, data[31:0]}
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [IDW-1:0] aw_id, ar_id, b_id, r_id;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region, w_strb;
  logic        aw_lock, ar_lock, aw_valid, aw_ready, ar_valid, ar_ready;
  logic        w_last, w_valid, w_ready, b_valid, b_ready, r_last, r_valid, r_ready;
  logic [UW-1:0] aw_user, ar_user, w_user, b_user, r_user;
  logic        busy_o, done_irq_o;

  wide_alu_axi_slave #(.AXI_ID_WIDTH(IDW), .AXI_USER_WIDTH(UW), .WIDE_WIDTH(256)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_aw_id(aw_id), .slv_aw_addr(aw_addr), .slv_aw_len(aw_len), .slv_aw_size(aw_size),
    .slv_aw_burst(aw_burst), .slv_aw_lock(aw_lock), .slv_aw_cache(aw_cache),
    .slv_aw_prot(aw_prot), .slv_aw_qos(aw_qos), .slv_aw_region(aw_region),
    .slv_aw_user(aw_user), .slv_aw_valid(aw_valid), .slv_aw_ready(aw_ready),
    .slv_w_data(w_data), .slv_w_strb(w_strb), .slv_w_last(w_last), .slv_w_user(w_user),
    .slv_w_valid(w_valid), .slv_w_ready(w_ready),
    .slv_b_id(b_id), .slv_b_resp(b_resp), .slv_b_user(b_user), .slv_b_valid(b_valid),
    .slv_b_ready(b_ready),
    .slv_ar_id(ar_id), .slv_ar_addr(ar_addr), .slv_ar_len(ar_len), .slv_ar_size(ar_size),
    .slv_ar_burst(ar_burst), .slv_ar_lock(ar_lock), .slv_ar_cache(ar_cache),
    .slv_ar_prot(ar_prot), .slv_ar_qos(ar_qos), .slv_ar_region(ar_region),
    .slv_ar_user(ar_user), .slv_ar_valid(ar_valid), .slv_ar_ready(ar_ready),
    .slv_r_id(r_id), .slv_r_data(r_data), .slv_r_resp(r_resp), .slv_r_last(r_last),
    .slv_r_user(r_user), .slv_r_valid(r_valid), .slv_r_ready(r_ready),
    .busy_o(busy_o), .done_irq_o(done_irq_o)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0] wbuf[16];
  int busy_cnt = 0;
  int irq_cnt = 0;

  // Counts edges where busy/irq were high just before the edge.
  always @(posedge clk) begin
    if (busy_o) busy_cnt++;
    if (done_irq_o) irq_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pop_exp();
    if (exp_q.size() == 0) return '1;
    return exp_q.pop_front();
  endfunction

  // All phase tasks are entered and left just after a falling edge.
  task automatic aw_phase(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int t = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_valid = 1'b1;
    #1;
    while (!aw_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!aw_ready) check("aw_accept", W'(aw_ready), W'(1));
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id);
    int t = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_valid = 1'b1;
    #1;
    while (!ar_ready && t < 50) begin @(negedge clk); #1; t++; end
    if (!ar_ready) check("ar_accept", W'(ar_ready), W'(1));
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  task automatic w_phase(input int len, input logic [3:0] strb);
    for (int b = 0; b <= len; b++) begin
      int t = 0;
      w_data = wbuf[b]; w_strb = strb; w_last = (b == len); w_valid = 1'b1;
      #1;
      while (!w_ready && t < 50) begin @(negedge clk); #1; t++; end
      if (!w_ready) check("w_accept", W'(w_ready), W'(1));
      @(negedge clk);
    end
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic b_phase();
    int t = 0;
    logic [W-1:0] e;
    b_ready = 1'b1;
    #1;
    while (!b_valid && t < 50) begin @(negedge clk); #1; t++; end
    e = pop_exp();
    if (!b_valid) check("b_valid", W'(b_valid), W'(1));
    else check("bresp", {b_id, b_resp, 1'b0, 32'd0}, e);
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic r_phase(input int len);
    r_ready = 1'b1;
    for (int b = 0; b <= len; b++) begin
      int t = 0;
      logic [W-1:0] e;
      #1;
      while (!r_valid && t < 50) begin @(negedge clk); #1; t++; end
      e = pop_exp();
      if (!r_valid) check("r_valid", W'(r_valid), W'(1));
      else check("rbeat", {r_id, r_resp, r_last, r_data}, e);
      @(negedge clk);
    end
    r_ready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input int len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] id, input logic [3:0] strb,
                    input logic [1:0] resp);
    exp_q.push_back({id, resp, 1'b0, 32'd0});
    aw_phase(addr, 8'(len), size, burst, id);
    w_phase(len, strb);
    b_phase();
  endtask

  task automatic exp_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                       input logic last);
    exp_q.push_back({id, resp, last, data});
  endtask

  task automatic rd(input logic [31:0] addr, input int len, input logic [2:0] size,
                    input logic [1:0] burst, input logic [3:0] id);
    ar_phase(addr, 8'(len), size, burst, id);
    r_phase(len);
  endtask

  task automatic wr1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    wbuf[0] = data;
    wr(addr, 0, 3'd2, 2'b01, 4'd1, 4'hF, resp);
  endtask

  task automatic rd1(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    exp_r(4'd2, data, resp, 1'b1);
    rd(addr, 0, 3'd2, 2'b01, 4'd2);
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) wbuf[i] = v;
  endtask

  task automatic rd_res(input logic [31:0] v);
    for (int i = 0; i < 8; i++) exp_r(4'd4, v, OK, i == 7);
    rd(32'h200, 7, 3'd2, 2'b01, 4'd4);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy_o && t < 100) begin @(negedge clk); t++; end
    if (busy_o) check("busy_end", W'(busy_o), W'(0));
    @(negedge clk);
    @(negedge clk);
  endtask

  int bb, ib, t;

  initial begin
    aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_lock = 1'b0;
    aw_cache = '0; aw_prot = '0; aw_qos = '0; aw_region = '0; aw_user = '0; aw_valid = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_lock = 1'b0;
    ar_cache = '0; ar_prot = '0; ar_qos = '0; ar_region = '0; ar_user = '0; ar_valid = 1'b0;
    w_data = '0; w_strb = '0; w_last = 1'b0; w_user = '0; w_valid = 1'b0;
    b_ready = 1'b0; r_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", W'({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last, busy_o,
                                done_irq_o, b_id, r_data}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd1(32'h304, 32'h0, OK);
    rd1(32'h300, 32'h0, OK);

    // ADD: all-ones + 1 wraps to zero with carry out
    fill(32'hFFFF_FFFF);
    wr(32'h000, 7, 3'd2, 2'b01, 4'd3, 4'hF, OK);
    fill(32'h0); wbuf[0] = 32'h1;
    wr(32'h100, 7, 3'd2, 2'b01, 4'd3, 4'hF, OK);
    bb = busy_cnt; ib = irq_cnt;
    wr1(32'h300, 32'h10, OK);
    wait_idle();
    check("add_busy_cycles", W'(busy_cnt - bb), W'(8));
    check("add_irq_pulses", W'(irq_cnt - ib), W'(1));
    rd_res(32'h0);
    rd1(32'h304, 32'h6, OK);

    // W1C clears done, carry untouched
    wr1(32'h304, 32'h2, OK);
    rd1(32'h304, 32'h4, OK);

    // SUB: 0 - 1
    fill(32'h0);
    wr(32'h000, 7, 3'd2, 2'b01, 4'd3, 4'hF, OK);
    wr1(32'h300, 32'h11, OK);
    wait_idle();
    rd_res(32'hFFFF_FFFF);
    rd1(32'h304, 32'h2, OK);

    // XOR and AND on identical operands
    fill(32'hA5A5_A5A5);
    wr(32'h000, 7, 3'd2, 2'b01, 4'd3, 4'hF, OK);
    wr(32'h100, 7, 3'd2, 2'b01, 4'd3, 4'hF, OK);
    wr1(32'h300, 32'h12, OK);
    wait_idle();
    rd_res(32'h0);
    rd1(32'h304, 32'h2, OK);
    rd1(32'h300, 32'h2, OK);
    wr1(32'h300, 32'h13, OK);
    wait_idle();
    rd1(32'h20C, 32'hA5A5_A5A5, OK);

    // INCR write burst 1..8, read back with distinct IDs
    for (int i = 0; i < 8; i++) wbuf[i] = 32'(i + 1);
    wr(32'h100, 7, 3'd2, 2'b01, 4'd5, 4'hF, OK);
    for (int i = 0; i < 8; i++) exp_r(4'd9, 32'(i + 1), OK, i == 7);
    rd(32'h100, 7, 3'd2, 2'b01, 4'd9);

    // FIXED burst stays on one word
    wbuf[0] = 32'h11; wbuf[1] = 32'h22;
    wr(32'h010, 1, 3'd2, 2'b00, 4'd3, 4'hF, OK);
    rd1(32'h010, 32'h22, OK);
    rd1(32'h014, 32'hA5A5_A5A5, OK);

    // Partial strobe
    wr1(32'h000, 32'h0, OK);
    wbuf[0] = 32'hDEAD_BEEF;
    wr(32'h000, 0, 3'd2, 2'b01, 4'd1, 4'b0010, OK);
    rd1(32'h000, 32'h0000_BE00, OK);

    // Error responses
    wr1(32'h200, 32'h1234_5678, SLV);
    rd1(32'h200, 32'hA5A5_A5A5, OK);
    rd1(32'h020, 32'h0, SLV);
    rd1(32'h308, 32'h0, SLV);
    wbuf[0] = 32'h55;
    wr(32'h004, 0, 3'd1, 2'b01, 4'd1, 4'hF, SLV);
    rd1(32'h004, 32'hA5A5_A5A5, OK);
    exp_r(4'd2, 32'h0, SLV, 1'b1);
    rd(32'h004, 0, 3'd1, 2'b01, 4'd2);
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    wr(32'h01C, 1, 3'd2, 2'b01, 4'd3, 4'hF, SLV);
    exp_r(4'd6, 32'h77, OK, 1'b0);
    exp_r(4'd6, 32'h0, SLV, 1'b1);
    rd(32'h01C, 1, 3'd2, 2'b01, 4'd6);
    wr1(32'h300, 32'h12, OK);
    wr1(32'h000, 32'hCAFE_F00D, SLV);
    wait_idle();
    rd1(32'h000, 32'h0000_BE00, OK);

    // AW and AR presented together: write first, read sees new data
    wbuf[0] = 32'h1234_5678;
    ar_id = 4'd7; ar_addr = 32'h104; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b01;
    ar_valid = 1'b1;
    aw_id = 4'd6; aw_addr = 32'h104; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'b01;
    aw_valid = 1'b1;
    #1;
    check("aw_wins", W'({aw_ready, ar_ready}), W'(2'b10));
    exp_q.push_back({4'd6, OK, 1'b0, 32'd0});
    aw_phase(32'h104, 8'd0, 3'd2, 2'b01, 4'd6);
    w_phase(0, 4'hF);
    b_phase();
    exp_r(4'd7, 32'h1234_5678, OK, 1'b1);
    ar_phase(32'h104, 8'd0, 3'd2, 2'b01, 4'd7);
    r_phase(0);

    // W1C on the completion edge: set wins
    wr1(32'h304, 32'h2, OK);
    rd1(32'h304, 32'h0, OK);
    bb = busy_cnt;
    wr1(32'h300, 32'h12, OK);
    exp_q.push_back({4'd8, OK, 1'b0, 32'd0});
    aw_phase(32'h304, 8'd0, 3'd2, 2'b01, 4'd8);
    t = 0;
    while (busy_cnt - bb < 7 && t < 100) begin @(negedge clk); t++; end
    check("busy_before_w1c", W'(busy_cnt - bb), W'(7));
    wbuf[0] = 32'h2;
    w_phase(0, 4'h1);
    b_phase();
    wait_idle();
    rd1(32'h304, 32'h2, OK);

    // Reset in the middle of a write burst
    aw_phase(32'h100, 8'd7, 3'd2, 2'b01, 4'd3);
    for (int i = 0; i < 3; i++) begin
      w_data = 32'hF0 + 32'(i); w_strb = 4'hF; w_last = 1'b0; w_valid = 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    check("midburst_reset_outputs", W'({aw_ready, ar_ready, w_ready, b_valid, r_valid, r_last,
                                         busy_o, done_irq_o, b_id, r_data}), W'(0));
    w_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd1(32'h100, 32'h0, OK);
    rd1(32'h304, 32'h0, OK);
    wr1(32'h000, 32'h0BAD_CAFE, OK);
    rd1(32'h000, 32'h0BAD_CAFE, OK);

    check("exp_q_drained", W'(exp_q.size()), W'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
